// File: rtl/qsys_sdram_cpu_oci_dct_unpacker.sv
// qsys_sdram_cpu_oci_dct_unpacker: unpacks trace frames into one 2-bit code per cycle with test-end drain
module qsys_sdram_cpu_oci_dct_unpacker #(
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dct_valid,
  output logic                       dct_ready,
  input  logic [29:0]                dct_buffer,
  input  logic [3:0]                 dct_count,
  output logic                       code_valid,
  input  logic                       code_ready,
  output logic [1:0]                 code,
  output logic [3:0]                 code_index,
  output logic                       code_last,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  input  logic                       test_ending,
  output logic                       test_has_ended
);
  typedef enum logic {IDLE, EMIT} state_t;
  state_t                     r_state;
  logic [29:0]                r_shreg;
  logic [3:0]                 r_remaining;
  logic [3:0]                 r_code_index;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_cnt;
  logic                       r_end_pending;
  logic                       r_test_has_ended;
  logic                       w_emit;
  logic                       w_last;
  // Outputs decode straight from registers; nothing here sees dct_valid
  always_comb begin
    w_emit         = r_state == EMIT;
    w_last         = w_emit && r_remaining == 4'd1;
    dct_ready      = r_state == IDLE && !r_end_pending && !r_test_has_ended;
    code_valid     = w_emit;
    code           = w_emit ? r_shreg[1:0] : 2'b00;
    code_index     = r_code_index;
    code_last      = w_last;
    frame_cnt      = r_frame_cnt;
    test_has_ended = r_test_has_ended;
  end
  // Frame capture, per-code shifting and sticky drain tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_shreg          <= '0;
      r_remaining      <= '0;
      r_code_index     <= '0;
      r_frame_cnt      <= '0;
      r_end_pending    <= 1'b0;
      r_test_has_ended <= 1'b0;
    end else begin
      if (test_ending) r_end_pending <= 1'b1;
      if (r_end_pending && r_state == IDLE) r_test_has_ended <= 1'b1;
      if (r_state == IDLE) begin
        if (dct_valid && dct_ready && dct_count != 4'd0) begin
          r_shreg      <= dct_buffer;
          r_remaining  <= dct_count;
          r_code_index <= 4'd0;
          r_state      <= EMIT;
        end
      end else if (code_ready) begin
        r_shreg      <= {2'b00, r_shreg[29:2]};
        r_remaining  <= r_remaining - 4'd1;
        r_code_index <= w_last ? 4'd0 : r_code_index + 4'd1;
        if (w_last) begin
          r_state     <= IDLE;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_qsys_sdram_cpu_oci_dct_unpacker.sv
// tb_qsys_sdram_cpu_oci_dct_unpacker: directed and randomized checks of the trace frame unpacker
module tb_qsys_sdram_cpu_oci_dct_unpacker;
  logic        clk = 0;
  logic        reset = 0;
  logic        dct_valid = 0;
  logic        dct_ready;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        code_valid;
  logic        code_ready = 0;
  logic [1:0]  code;
  logic [3:0]  code_index;
  logic        code_last;
  logic [15:0] frame_cnt;
  logic        test_ending = 0;
  logic        test_has_ended;

  logic        w_dct_valid = 0;
  logic        w_dct_ready;
  logic [29:0] w_dct_buffer = '0;
  logic [3:0]  w_dct_count = '0;
  logic        w_code_valid;
  logic        w_code_ready = 0;
  logic [1:0]  w_code;
  logic [3:0]  w_code_index;
  logic        w_code_last;
  logic [1:0]  w_frame_cnt;
  logic        w_test_ending = 0;
  logic        w_test_has_ended;

  int n_checks = 0;
  int n_fail = 0;
  int exp_fcnt = 0;

  typedef struct {
    logic [1:0] c;
    logic [3:0] i;
    logic       l;
  } code_t;
  code_t q[$];

  qsys_sdram_cpu_oci_dct_unpacker dut (
    .clk(clk), .reset(reset), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .code_valid(code_valid),
    .code_ready(code_ready), .code(code), .code_index(code_index),
    .code_last(code_last), .frame_cnt(frame_cnt), .test_ending(test_ending),
    .test_has_ended(test_has_ended)
  );

  qsys_sdram_cpu_oci_dct_unpacker #(.FRAME_CNT_WIDTH(2)) u_w (
    .clk(clk), .reset(reset), .dct_valid(w_dct_valid), .dct_ready(w_dct_ready),
    .dct_buffer(w_dct_buffer), .dct_count(w_dct_count), .code_valid(w_code_valid),
    .code_ready(w_code_ready), .code(w_code), .code_index(w_code_index),
    .code_last(w_code_last), .frame_cnt(w_frame_cnt), .test_ending(w_test_ending),
    .test_has_ended(w_test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    dct_valid = 0;
    code_ready = 0;
    test_ending = 0;
    #3;
    step();
    reset = 0;
    step();
    exp_fcnt = 0;
    q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (code_valid !== 1'b0 || code !== 2'd0 || code_index !== 4'd0 || code_last !== 1'b0 ||
        dct_ready !== 1'b1 || frame_cnt !== 16'd0 || test_has_ended !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: valid=%b code=%0d idx=%0d last=%b rdy=%b fcnt=%0d ended=%b required 0 0 0 0 1 0 0",
               code_valid, code, code_index, code_last, dct_ready, frame_cnt, test_has_ended);
    end
  endtask

  task automatic test_single();
    dct_valid = 1; dct_buffer = 30'h0000_00E4; dct_count = 4; code_ready = 1;
    n_checks++;
    if (dct_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_before: got %b required 1", dct_ready); end
    step();
    dct_valid = 0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (code_valid !== 1'b1 || code !== 2'(k) || code_index !== 4'(k) ||
          code_last !== (k == 3) || dct_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL single_code%0d: valid=%b code=%0d idx=%0d last=%b rdy=%b required 1 %0d %0d %b 0",
                 k, code_valid, code, code_index, code_last, dct_ready, k, k, k == 3);
      end
      step();
    end
    exp_fcnt++;
    n_checks++;
    if (code_valid !== 1'b0 || dct_ready !== 1'b1 || frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL single_after: valid=%b rdy=%b fcnt=%0d required 0 1 %0d", code_valid, dct_ready, frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    int cyc = 0;
    dct_valid = 1; dct_buffer = 30'h3FFF_FFFF; dct_count = 15; code_ready = 1;
    step();
    dct_valid = 0;
    while (xfers < 15 && cyc < 60) begin
      code_ready = (cyc % 2) == 0;
      n_checks++;
      if (code_valid !== 1'b1 || code !== 2'd3 || code_index !== 4'(xfers) || code_last !== (xfers == 14)) begin
        n_fail++;
        $display("FAIL bp_code: valid=%b code=%0d idx=%0d last=%b required 1 3 %0d %b",
                 code_valid, code, code_index, code_last, xfers, xfers == 14);
      end
      if (code_ready && code_valid) xfers++;
      cyc++;
      step();
    end
    code_ready = 1;
    exp_fcnt++;
    n_checks++;
    if (xfers != 15 || code_valid !== 1'b0 || frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL bp_done: xfers=%0d valid=%b fcnt=%0d required 15 0 %0d", xfers, code_valid, frame_cnt, exp_fcnt);
    end
  endtask

  task automatic test_empty();
    dct_valid = 1; dct_buffer = 30'h1555_5555; dct_count = 0;
    step();
    dct_valid = 0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (code_valid !== 1'b0 || dct_ready !== 1'b1 || frame_cnt !== 16'(exp_fcnt)) begin
        n_fail++;
        $display("FAIL empty: valid=%b rdy=%b fcnt=%0d required 0 1 %0d", code_valid, dct_ready, frame_cnt, exp_fcnt);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [3:0]  cnt;
    logic [29:0] buff;
    int bad = 0;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++;
      if (q.size() != 0) begin
        if (code_valid !== 1'b1 || code !== q[0].c || code_index !== q[0].i ||
            code_last !== q[0].l || dct_ready !== 1'b0) begin
          n_fail++; bad++;
          if (bad < 10)
            $display("FAIL rand_emit cyc%0d: valid=%b code=%0d idx=%0d last=%b rdy=%b required 1 %0d %0d %b 0",
                     cyc, code_valid, code, code_index, code_last, dct_ready, q[0].c, q[0].i, q[0].l);
        end
      end else if (code_valid !== 1'b0 || dct_ready !== 1'b1 || frame_cnt !== 16'(exp_fcnt)) begin
        n_fail++; bad++;
        if (bad < 10)
          $display("FAIL rand_idle cyc%0d: valid=%b rdy=%b fcnt=%0d required 0 1 %0d",
                   cyc, code_valid, dct_ready, frame_cnt, exp_fcnt);
      end
      cnt = 4'($urandom_range(0, 15));
      buff = 30'($urandom);
      dct_valid = $urandom_range(0, 2) != 0;
      dct_count = cnt;
      dct_buffer = buff;
      code_ready = $urandom_range(0, 3) != 0;
      if (q.size() == 0) begin
        if (dct_valid)
          for (int i = 0; i < cnt; i++) q.push_back('{2'((buff >> (2 * i)) & 3), 4'(i), i == cnt - 1});
      end else if (code_ready) begin
        if (q[0].l) exp_fcnt++;
        void'(q.pop_front());
      end
      step();
    end
    dct_valid = 0;
    code_ready = 1;
    for (int k = 0; k < 20 && code_valid; k++) step();
  endtask

  task automatic test_reset_mid();
    dct_valid = 1; dct_buffer = 30'($urandom); dct_count = 10; code_ready = 1;
    step();
    dct_valid = 0;
    for (int k = 0; k < 5; k++) step();
    n_checks++;
    if (code_valid !== 1'b1 || code_index !== 4'd5) begin
      n_fail++; $display("FAIL rmid_pre: valid=%b idx=%0d required 1 5", code_valid, code_index);
    end
    #1 reset = 1;
    #1;
    n_checks++;
    if (code_valid !== 1'b0 || code_index !== 4'd0) begin
      n_fail++; $display("FAIL rmid_async: valid=%b idx=%0d required 0 0", code_valid, code_index);
    end
    step();
    #2 reset = 0;
    exp_fcnt = 0;
    step();
    n_checks++;
    if (dct_ready !== 1'b1 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rmid_post: rdy=%b fcnt=%0d required 1 0", dct_ready, frame_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (code_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: valid=%b required 0", code_valid); end
      step();
    end
  endtask

  task automatic test_drain();
    logic [1:0] exp[3] = '{2'd2, 2'd3, 2'd1};
    dct_valid = 1; dct_buffer = 30'h0000_001E; dct_count = 3; code_ready = 1;
    step();
    dct_valid = 0;
    for (int k = 0; k < 3; k++) begin
      test_ending = k == 1;
      n_checks++;
      if (code_valid !== 1'b1 || code !== exp[k] || code_index !== 4'(k) || test_has_ended !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_code%0d: valid=%b code=%0d idx=%0d ended=%b required 1 %0d %0d 0",
                 k, code_valid, code, code_index, test_has_ended, exp[k], k);
      end
      step();
    end
    test_ending = 0;
    exp_fcnt++;
    n_checks++;
    if (code_valid !== 1'b0 || dct_ready !== 1'b0 || test_has_ended !== 1'b0 || frame_cnt !== 16'(exp_fcnt)) begin
      n_fail++;
      $display("FAIL drain_idle: valid=%b rdy=%b ended=%b fcnt=%0d required 0 0 0 %0d",
               code_valid, dct_ready, test_has_ended, frame_cnt, exp_fcnt);
    end
    step();
    n_checks++;
    if (test_has_ended !== 1'b1) begin n_fail++; $display("FAIL drain_ended: got %b required 1", test_has_ended); end
    dct_valid = 1; dct_count = 5;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (dct_ready !== 1'b0 || code_valid !== 1'b0 || test_has_ended !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_block: rdy=%b valid=%b ended=%b required 0 0 1", dct_ready, code_valid, test_has_ended);
      end
      step();
    end
    dct_valid = 0;
  endtask

  task automatic test_simul_end();
    logic [29:0] b;
    do_reset();
    b = 30'($urandom);
    dct_valid = 1; dct_buffer = b; dct_count = 2; code_ready = 1; test_ending = 1;
    n_checks++;
    if (dct_ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b required 1", dct_ready); end
    step();
    dct_valid = 0; test_ending = 0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (code_valid !== 1'b1 || code !== 2'((b >> (2 * k)) & 3) || code_last !== (k == 1) || test_has_ended !== 1'b0) begin
        n_fail++;
        $display("FAIL simul_code%0d: valid=%b code=%0d last=%b ended=%b required 1 %0d %b 0",
                 k, code_valid, code, code_last, test_has_ended, (b >> (2 * k)) & 3, k == 1);
      end
      step();
    end
    n_checks++;
    if (code_valid !== 1'b0 || test_has_ended !== 1'b0 || dct_ready !== 1'b0) begin
      n_fail++; $display("FAIL simul_idle: valid=%b ended=%b rdy=%b required 0 0 0", code_valid, test_has_ended, dct_ready);
    end
    step();
    n_checks++;
    if (test_has_ended !== 1'b1) begin n_fail++; $display("FAIL simul_ended: got %b required 1", test_has_ended); end
  endtask

  task automatic test_wrap();
    w_code_ready = 1;
    w_dct_count = 1;
    for (int f = 0; f < 5; f++) begin
      w_dct_buffer = 30'($urandom);
      w_dct_valid = 1;
      step();
      w_dct_valid = 0;
      step();
    end
    n_checks++;
    if (w_frame_cnt !== 2'd1) begin n_fail++; $display("FAIL wrap_fcnt: got %0d required 1", w_frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_empty();
    test_random();
    test_reset_mid();
    test_drain();
    test_simul_end();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
